naive_bus_uart_tx_slave: RTL and testbench

- naive_bus responder: a memory-mapped UART transmitter for the core's data_master, reached through the SoC bus router.
- Accepts byte writes into a TX FIFO and serialises them 8N1 on `tx`.
- Exposes status and baud-divisor registers.
- Exerts write backpressure: `wr_gnt` is withheld when the FIFO is full, which the master sees as a bus conflict/stall.

---
 rtl/naive_uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/naive_bus_uart_tx_slave.sv | 173 +++++++++++++++++
 tb/tb_naive_bus_uart_tx_slave.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/naive_uart_pkg.sv
// Shared constants and types for the naive_bus UART transmitter responder.
package naive_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // A divisor of zero still needs a one-cycle bit.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head word; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = do_push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/naive_bus_uart_tx_slave.sv
// naive_bus responder: byte writes queue into a TX FIFO and are sent 8N1 on tx.
module naive_bus_uart_tx_slave
    import naive_uart_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    output logic        rd_gnt,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        wr_req,
    output logic        wr_gnt,
    input  logic [31:0] wr_addr,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    output logic        tx,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t     state_q, state_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   period_q, period_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d;
    logic [31:0]   rd_data_q, rd_data_d, rd_mux_s;

    logic          push_s, pop_s, full_s, empty_s, busy_s;
    logic [7:0]    head_s;
    logic [CW-1:0] count_s;
    logic [8:0]    count_ext_s;
    logic          txdata_be0_s, div_we_s;
    logic          unused_s;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (wr_data[7:0]),
        .dout_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign count_ext_s  = 9'(count_s);
    assign busy_s       = (state_q != TX_IDLE);
    assign txdata_be0_s = (wr_addr[3:2] == REG_TXDATA) & wr_be[0];
    // A push into a full FIFO stalls even if the transmitter pops this cycle.
    assign wr_gnt       = wr_req & ~(txdata_be0_s & full_s);
    assign push_s       = wr_req & txdata_be0_s & ~full_s;
    assign rd_gnt       = rd_req;
    assign div_we_s     = wr_req & (wr_addr[3:2] == REG_DIVISOR);
    assign div_d[7:0]   = (div_we_s & wr_be[0]) ? wr_data[7:0]  : div_q[7:0];
    assign div_d[15:8]  = (div_we_s & wr_be[1]) ? wr_data[15:8] : div_q[15:8];
    assign irq_d        = empty_s & ~busy_s;
    assign rd_data_d    = rd_req ? rd_mux_s : rd_data_q;
    assign rd_data      = rd_data_q;
    assign tx           = tx_q;
    assign irq          = irq_q;
    assign unused_s     = ^{rd_addr[31:4], rd_addr[1:0], wr_addr[31:4], wr_addr[1:0],
                            wr_data[31:16], wr_be[3:2], count_ext_s[8]};

    // Read-data mux.
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_addr[3:2])
            REG_STATUS: begin
                rd_mux_s[ST_COUNT_LSB +: 8] = count_ext_s[7:0];
                rd_mux_s[ST_EMPTY_BIT]      = empty_s;
                rd_mux_s[ST_FULL_BIT]       = full_s;
                rd_mux_s[ST_BUSY_BIT]       = busy_s;
            end
            REG_DIVISOR: rd_mux_s = {16'd0, div_q};
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Transmitter next state; tx_d anticipates the level of the state being entered.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop_s    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = head_s;
                    period_d = bit_period(div_q);
                    cnt_d    = bit_period(div_q) - 16'd1;
                    state_d  = TX_START;
                    tx_d     = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            TX_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = TX_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = period_q - 16'd1;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = period_q - 16'd1;
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == 16'd0) begin
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            div_q     <= DIV_RESET;
            period_q  <= 16'd1;
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
            rd_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_naive_bus_uart_tx_slave.sv
// Scoreboard bench: expected frames/read data are queued at issue time and checked by monitors.
module tb_naive_bus_uart_tx_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0, rd_gnt;
    logic [31:0] rd_addr = 32'd0, rd_data;
    logic        wr_req = 1'b0, wr_gnt;
    logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;
    logic [3:0]  wr_be = 4'd0;
    logic        tx, irq;

    naive_bus_uart_tx_slave #(.DEPTH(8), .DIV_RESET(16'd868)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         p;
    } frame_t;

    frame_t      exp_q[$];
    logic [31:0] rd_exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_start = 0;
    bit          mon_en = 1'b1;
    bit          in_frame = 1'b0;
    logic [15:0] model_div = 16'd868;
    logic        rd_fire = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff_p(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    // Read monitor: one cycle after a granted read, compare against the queued value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_fire <= 1'b0;
        else        rd_fire <= rd_req & rd_gnt;
    end
    always @(negedge clk) begin
        if (rd_fire) begin
            if (rd_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", rd_data);
            end else begin
                chk("rd_data", rd_data, rd_exp_q.pop_front());
            end
        end
    end

    // Serial monitor: on a start edge, sample the whole 10-bit frame against the queued byte.
    initial begin
        bit         prev;
        logic [7:0] got;
        int         errs, p;
        logic       e;
        frame_t     f;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && prev && (tx === 1'b0)) begin
                in_frame   = 1'b1;
                last_start = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: start bit at cycle %0d, none expected", cyc);
                end else begin
                    f = exp_q.pop_front();
                    p = f.p;
                    errs = 0;
                    got = 8'd0;
                    for (int k = 0; k < 10 * p; k++) begin
                        if (k > 0) @(negedge clk);
                        if (k < p)          e = 1'b0;
                        else if (k < 9 * p) e = f.b[(k - p) / p];
                        else                e = 1'b1;
                        if (tx !== e) errs++;
                        if (k >= p && k < 9 * p && ((k - p) % p) == p / 2) got[(k - p) / p] = tx;
                    end
                    chk("tx_byte", {24'd0, got}, {24'd0, f.b});
                    chk("tx_frame_bit_errors", errs, 0);
                end
                in_frame = 1'b0;
            end
            prev = tx;
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, output int t_gnt);
        int stalls;
        stalls  = 0;
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
        #1;
        while (!wr_gnt && stalls < 2000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!wr_gnt) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_gnt_timeout: got no grant after %0d cycles expected grant", stalls);
        end
        t_gnt = cyc;
        if (addr[3:2] == 2'd2) begin
            if (be[0]) model_div[7:0]  = data[7:0];
            if (be[1]) model_div[15:8] = data[15:8];
        end
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int p, output int t_gnt);
        frame_t f;
        f.b = b;
        f.p = p;
        exp_q.push_back(f);
        bus_write(32'h0, {24'd0, b}, 4'b0001, t_gnt);
    endtask

    task automatic set_div(input logic [15:0] d);
        int t;
        bus_write(32'h8, {16'hABCD, d}, 4'b1111, t);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
        rd_req  = 1'b1;
        rd_addr = addr;
        #1;
        chk("rd_gnt", {31'd0, rd_gnt}, 32'd1);
        rd_exp_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || in_frame) && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
        end
        wait_cycles(3);
        chk("irq_idle", {31'd0, irq}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t0, tg[10], zeros;
        logic [15:0] d;
        int n;

        // Reset values
        wait_cycles(3);
        rst_n = 1'b1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd1);
        bus_read(32'h4, 32'h0000_0004);
        bus_read(32'h8, 32'h0000_0364);
        bus_read(32'h0, 32'h0000_0000);
        bus_read(32'hC, 32'h0000_0000);

        // Byte enables
        bus_write(32'h0, 32'h0000_00AA, 4'b1110, t);
        wait_cycles(2);
        bus_read(32'h4, 32'h0000_0004);
        bus_write(32'h8, 32'h0000_1234, 4'b0001, t);
        bus_read(32'h8, {16'd0, model_div});
        bus_read(32'h8, 32'h0000_0334);

        // Single 0x55 frame at divisor 4, plus latency and mid-frame STATUS
        set_div(16'd4);
        send_byte(8'h55, eff_p(model_div), t);
        wait_cycles(4);
        bus_read(32'h4, 32'h0000_0005);
        wait_idle();
        chk("start_latency", last_start - t, 2);

        // Backpressure: 10 writes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) send_byte(8'(8'hA0 + i), 4, tg[i]);
        bus_read(32'h4, 32'h0000_0803);
        send_byte(8'hA9, 4, tg[9]);
        t0 = tg[0];
        chk("bp_ninth_grant", tg[8] - t0, 8);
        chk("bp_tenth_grant_cycle", tg[9] - t0, 43);
        wait_idle();

        // Divisor change mid-frame affects only the following frame
        set_div(16'd4);
        send_byte(8'hC3, 4, t);
        send_byte(8'h3C, 2, t);
        wait_cycles(12);
        set_div(16'd2);
        wait_idle();
        set_div(16'd0);
        send_byte(8'h96, 1, t);
        wait_idle();

        // Randomized groups
        for (int g = 0; g < 6; g++) begin
            d = 16'($urandom_range(0, 5));
            set_div(d);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) send_byte(8'($urandom), eff_p(model_div), t);
            wait_idle();
        end

        // Reset mid-frame with bytes queued
        set_div(16'd4);
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(32'h0, {24'd0, 8'(8'h10 + i)}, 4'b0001, t);
        wait_cycles(15);
        #2;
        rst_n = 1'b0;
        model_div = 16'd868;
        #1;
        chk("async_reset_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'h4, 32'h0000_0004);
        bus_read(32'h8, {16'd0, model_div});
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        chk("post_reset_no_tx", zeros, 0);
        chk("post_reset_irq", {31'd0, irq}, 32'd1);
        wait_cycles(2);
        chk("rd_queue_drained", rd_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
